// File: rtl/lsu_mm_pkg.sv
// Shared widths, FSM encoding and read-tag payload for the matmul load sequencer.
package lsu_mm_pkg;

   localparam int unsigned LINE_W = 128;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned LEN_W  = 4;
   localparam int unsigned CYC_W  = 6;
   localparam int unsigned BADR_W = 12;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_FETCH_A = 3'd1;
   localparam logic [2:0] ST_FETCH_B = 3'd2;
   localparam logic [2:0] ST_DRAIN   = 3'd3;
   localparam logic [2:0] ST_STREAM  = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   typedef struct packed {
      logic              vld;
      logic              sel_b;
      logic [ADDR_W-1:0] idx;
   } rd_tag_t;

endpackage

// File: rtl/lsu_mm_rd_tag_pipe.sv
// Delays each RAM read tag by RAM_RD_LAT cycles so it lines up with the returning data.
module lsu_mm_rd_tag_pipe
   import lsu_mm_pkg::*;
#(
   parameter int unsigned RAM_RD_LAT = 1
) (
   input  logic    clk,
   input  logic    rst_n,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out
);

   rd_tag_t pipe_q [RAM_RD_LAT];
   rd_tag_t pipe_d [RAM_RD_LAT];

   always_comb begin
      pipe_d[0] = tag_in;
      for (int i = 1; i < int'(RAM_RD_LAT); i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(RAM_RD_LAT); i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(RAM_RD_LAT); i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   assign tag_out = pipe_q[RAM_RD_LAT-1];

endmodule

// File: rtl/lsu_mm_seq.sv
// Matmul operand loader: fetches A then B lines from RAM into the operand
// buffers, waits for the read pipe to drain, then streams both buffers.
module lsu_mm_seq
   import lsu_mm_pkg::*;
#(
   parameter int unsigned RAM_RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lsu_mm_seq_req_vld,
   output logic              lsu_mm_seq_req_rdy,
   input  logic [LEN_W-1:0]  lsu_mm_seq_req_row_len,
   input  logic [LEN_W-1:0]  lsu_mm_seq_req_col_len,
   input  logic [BADR_W-1:0] lsu_mm_seq_req_a_addr,
   input  logic [BADR_W-1:0] lsu_mm_seq_req_b_addr,
   output logic              lsu_mm_seq_ram_read_vld,
   output logic [ADDR_W-1:0] lsu_mm_seq_ram_read_addr,
   input  logic [LINE_W-1:0] lsu_mm_seq_ram_rdata,
   output logic              lsu_mm_seq_a_alloc_vld,
   output logic              lsu_mm_seq_b_alloc_vld,
   output logic [ADDR_W-1:0] lsu_mm_seq_alloc_addr,
   output logic [LINE_W-1:0] lsu_mm_seq_alloc_data,
   output logic              lsu_mm_seq_a_ctrl_vld,
   output logic              lsu_mm_seq_b_ctrl_vld,
   output logic [LEN_W-1:0]  lsu_mm_seq_ctrl_row_len,
   output logic [LEN_W-1:0]  lsu_mm_seq_ctrl_col_len,
   output logic              lsu_mm_seq_done,
   output logic              lsu_mm_seq_err
);

   logic [2:0]        state_q, state_d;
   logic [CYC_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  row_len_q, row_len_d;
   logic [LEN_W-1:0]  col_len_q, col_len_d;
   logic [ADDR_W-1:0] a_line_q, a_line_d;
   logic [ADDR_W-1:0] b_line_q, b_line_d;
   logic              err_flag_q, err_flag_d;

   logic              req_rdy_q, req_rdy_d;
   logic              rd_vld_q, rd_vld_d;
   logic              rd_sel_b_q, rd_sel_b_d;
   logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              ctrl_vld_q, ctrl_vld_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   rd_tag_t           tag_in, tag_out;

   // Byte offset within a line does not affect which line is fetched.
   logic              unused_addr_lsb;
   assign unused_addr_lsb = ^{lsu_mm_seq_req_a_addr[3:0], lsu_mm_seq_req_b_addr[3:0]};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      row_len_d  = row_len_q;
      col_len_d  = col_len_q;
      a_line_d   = a_line_q;
      b_line_d   = b_line_q;
      err_flag_d = err_flag_q;

      case (state_q)
         ST_IDLE: begin
            if (lsu_mm_seq_req_vld) begin
               row_len_d  = lsu_mm_seq_req_row_len;
               col_len_d  = lsu_mm_seq_req_col_len;
               a_line_d   = lsu_mm_seq_req_a_addr[11:4];
               b_line_d   = lsu_mm_seq_req_b_addr[11:4];
               err_flag_d = (lsu_mm_seq_req_row_len == '0) || (lsu_mm_seq_req_col_len == '0);
               cnt_d      = '0;
               state_d    = err_flag_d ? ST_DONE : ST_FETCH_A;
            end
         end
         ST_FETCH_A: begin
            if (cnt_q == CYC_W'(row_len_q) - CYC_W'(1)) begin
               cnt_d   = '0;
               state_d = ST_FETCH_B;
            end else begin
               cnt_d = cnt_q + CYC_W'(1);
            end
         end
         ST_FETCH_B: begin
            if (cnt_q == CYC_W'(col_len_q) - CYC_W'(1)) begin
               cnt_d   = '0;
               state_d = ST_DRAIN;
            end else begin
               cnt_d = cnt_q + CYC_W'(1);
            end
         end
         ST_DRAIN: begin
            if (cnt_q == CYC_W'(RAM_RD_LAT - 1)) begin
               cnt_d   = '0;
               state_d = ST_STREAM;
            end else begin
               cnt_d = cnt_q + CYC_W'(1);
            end
         end
         ST_STREAM: begin
            if (cnt_q == CYC_W'(row_len_q) + CYC_W'(col_len_q) - CYC_W'(2)) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CYC_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they are registered yet cycle-aligned.
      req_rdy_d  = (state_d == ST_IDLE);
      rd_vld_d   = (state_d == ST_FETCH_A) || (state_d == ST_FETCH_B);
      rd_sel_b_d = (state_d == ST_FETCH_B);
      rd_idx_d   = ADDR_W'(cnt_d);
      rd_addr_d  = (rd_sel_b_d ? b_line_d : a_line_d) + ADDR_W'(cnt_d);
      ctrl_vld_d = (state_d == ST_STREAM);
      done_d     = (state_d == ST_DONE);
      err_d      = done_d && err_flag_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         row_len_q  <= '0;
         col_len_q  <= '0;
         a_line_q   <= '0;
         b_line_q   <= '0;
         err_flag_q <= 1'b0;
         req_rdy_q  <= 1'b1;
         rd_vld_q   <= 1'b0;
         rd_sel_b_q <= 1'b0;
         rd_idx_q   <= '0;
         rd_addr_q  <= '0;
         ctrl_vld_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         row_len_q  <= row_len_d;
         col_len_q  <= col_len_d;
         a_line_q   <= a_line_d;
         b_line_q   <= b_line_d;
         err_flag_q <= err_flag_d;
         req_rdy_q  <= req_rdy_d;
         rd_vld_q   <= rd_vld_d;
         rd_sel_b_q <= rd_sel_b_d;
         rd_idx_q   <= rd_idx_d;
         rd_addr_q  <= rd_addr_d;
         ctrl_vld_q <= ctrl_vld_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      tag_in       = '0;
      tag_in.vld   = rd_vld_q;
      tag_in.sel_b = rd_sel_b_q;
      tag_in.idx   = rd_idx_q;
   end

   lsu_mm_rd_tag_pipe #(
      .RAM_RD_LAT (RAM_RD_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign lsu_mm_seq_req_rdy       = req_rdy_q;
   assign lsu_mm_seq_ram_read_vld  = rd_vld_q;
   assign lsu_mm_seq_ram_read_addr = rd_addr_q;
   assign lsu_mm_seq_a_alloc_vld   = tag_out.vld && !tag_out.sel_b;
   assign lsu_mm_seq_b_alloc_vld   = tag_out.vld && tag_out.sel_b;
   assign lsu_mm_seq_alloc_addr    = tag_out.idx;
   assign lsu_mm_seq_alloc_data    = lsu_mm_seq_ram_rdata;
   assign lsu_mm_seq_a_ctrl_vld    = ctrl_vld_q;
   assign lsu_mm_seq_b_ctrl_vld    = ctrl_vld_q;
   assign lsu_mm_seq_ctrl_row_len  = row_len_q;
   assign lsu_mm_seq_ctrl_col_len  = col_len_q;
   assign lsu_mm_seq_done          = done_q;
   assign lsu_mm_seq_err           = err_q;

endmodule

// File: tb/tb_lsu_mm_seq.sv
// Directed bench for lsu_mm_seq: one instance at read latency 1, one at latency 3.
module tb_lsu_mm_seq;

   logic         clk;
   logic         rst_n;
   logic         req_vld;
   logic [3:0]   row, col;
   logic [11:0]  a_addr, b_addr;

   logic         rdy, rd_vld, a_alloc, b_alloc, a_ctrl, b_ctrl, done, err;
   logic [7:0]   rd_addr, alloc_addr;
   logic [127:0] alloc_data, rdata;
   logic [3:0]   ctrl_row, ctrl_col;

   logic         rdy_3, rd_vld_3, a_alloc_3, b_alloc_3, a_ctrl_3, b_ctrl_3, done_3, err_3;
   logic [7:0]   rd_addr_3, alloc_addr_3;
   logic [127:0] alloc_data_3, rdata_3, s1_3, s2_3;
   logic [3:0]   ctrl_row_3, ctrl_col_3;

   logic [7:0]   fl, fl_3;
   int           tests, fails;

   // Flag vector: {rdy, rd_vld, a_alloc, b_alloc, a_ctrl, b_ctrl, done, err}
   assign fl   = {rdy, rd_vld, a_alloc, b_alloc, a_ctrl, b_ctrl, done, err};
   assign fl_3 = {rdy_3, rd_vld_3, a_alloc_3, b_alloc_3, a_ctrl_3, b_ctrl_3, done_3, err_3};

   lsu_mm_seq #(.RAM_RD_LAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .lsu_mm_seq_req_vld(req_vld), .lsu_mm_seq_req_rdy(rdy),
      .lsu_mm_seq_req_row_len(row), .lsu_mm_seq_req_col_len(col),
      .lsu_mm_seq_req_a_addr(a_addr), .lsu_mm_seq_req_b_addr(b_addr),
      .lsu_mm_seq_ram_read_vld(rd_vld), .lsu_mm_seq_ram_read_addr(rd_addr),
      .lsu_mm_seq_ram_rdata(rdata),
      .lsu_mm_seq_a_alloc_vld(a_alloc), .lsu_mm_seq_b_alloc_vld(b_alloc),
      .lsu_mm_seq_alloc_addr(alloc_addr), .lsu_mm_seq_alloc_data(alloc_data),
      .lsu_mm_seq_a_ctrl_vld(a_ctrl), .lsu_mm_seq_b_ctrl_vld(b_ctrl),
      .lsu_mm_seq_ctrl_row_len(ctrl_row), .lsu_mm_seq_ctrl_col_len(ctrl_col),
      .lsu_mm_seq_done(done), .lsu_mm_seq_err(err)
   );

   lsu_mm_seq #(.RAM_RD_LAT(3)) u_dut_3 (
      .clk(clk), .rst_n(rst_n),
      .lsu_mm_seq_req_vld(req_vld), .lsu_mm_seq_req_rdy(rdy_3),
      .lsu_mm_seq_req_row_len(row), .lsu_mm_seq_req_col_len(col),
      .lsu_mm_seq_req_a_addr(a_addr), .lsu_mm_seq_req_b_addr(b_addr),
      .lsu_mm_seq_ram_read_vld(rd_vld_3), .lsu_mm_seq_ram_read_addr(rd_addr_3),
      .lsu_mm_seq_ram_rdata(rdata_3),
      .lsu_mm_seq_a_alloc_vld(a_alloc_3), .lsu_mm_seq_b_alloc_vld(b_alloc_3),
      .lsu_mm_seq_alloc_addr(alloc_addr_3), .lsu_mm_seq_alloc_data(alloc_data_3),
      .lsu_mm_seq_a_ctrl_vld(a_ctrl_3), .lsu_mm_seq_b_ctrl_vld(b_ctrl_3),
      .lsu_mm_seq_ctrl_row_len(ctrl_row_3), .lsu_mm_seq_ctrl_col_len(ctrl_col_3),
      .lsu_mm_seq_done(done_3), .lsu_mm_seq_err(err_3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM models: line content is the line address replicated across 16 bytes.
   always @(posedge clk) begin
      rdata   <= rd_vld ? {16{rd_addr}} : '0;
      s1_3    <= rd_vld_3 ? {16{rd_addr_3}} : '0;
      s2_3    <= s1_3;
      rdata_3 <= s2_3;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input int n);
      req_vld = 1'b0;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_vld = 1'b0;
      row = '0; col = '0; a_addr = '0; b_addr = '0;
      repeat (3) tick();
      tests++;
      if (fl !== 8'b1000_0000) begin
         fails++;
         $display("FAIL reset_flags got %b exp %b", fl, 8'b1000_0000);
      end
      tests++;
      if ({rd_addr, alloc_addr, ctrl_row, ctrl_col} !== 24'h0) begin
         fails++;
         $display("FAIL reset_fields got %h exp 000000", {rd_addr, alloc_addr, ctrl_row, ctrl_col});
      end
      tests++;
      if (fl_3 !== 8'b1000_0000) begin
         fails++;
         $display("FAIL reset_flags_lat3 got %b exp %b", fl_3, 8'b1000_0000);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [7:0] ef [12] = '{8'h40, 8'h60, 8'h60, 8'h50, 8'h50, 8'h10,
                              8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h02, 8'h80};
      logic [7:0] ra [5]  = '{8'h12, 8'h13, 8'h30, 8'h31, 8'h32};
      logic [7:0] ai [5]  = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd2};
      logic [7:0] dv;
      row = 4'd2; col = 4'd3; a_addr = 12'h120; b_addr = 12'h300;
      req_vld = 1'b1;
      tests++;
      if (rdy !== 1'b1) begin
         fails++;
         $display("FAIL basic_rdy_t0 got %b exp 1", rdy);
      end
      for (int t = 1; t <= 12; t++) begin
         tick();
         req_vld = 1'b0;
         tests++;
         if (fl !== ef[t-1]) begin
            fails++;
            $display("FAIL basic_flags t=%0d got %b exp %b", t, fl, ef[t-1]);
         end
         if (t <= 5) begin
            tests++;
            if (rd_addr !== ra[t-1]) begin
               fails++;
               $display("FAIL basic_rd_addr t=%0d got %h exp %h", t, rd_addr, ra[t-1]);
            end
         end
         if (t >= 2 && t <= 6) begin
            dv = ra[t-2];
            tests++;
            if (alloc_addr !== ai[t-2] || alloc_data !== {16{dv}}) begin
               fails++;
               $display("FAIL basic_alloc t=%0d got idx %h data %h exp idx %h data %h",
                        t, alloc_addr, alloc_data, ai[t-2], {16{dv}});
            end
         end
      end
      tests++;
      if (ctrl_row !== 4'd2 || ctrl_col !== 4'd3) begin
         fails++;
         $display("FAIL basic_ctrl_len got %0d/%0d exp 2/3", ctrl_row, ctrl_col);
      end
      settle(20);
   endtask

   task automatic test_error();
      row = 4'd0; col = 4'd5; a_addr = 12'h120; b_addr = 12'h300;
      req_vld = 1'b1;
      for (int t = 1; t <= 3; t++) begin
         tick();
         req_vld = 1'b0;
         tests++;
         if (t == 1 && fl !== 8'b0000_0011) begin
            fails++;
            $display("FAIL err_done t=%0d got %b exp %b", t, fl, 8'b0000_0011);
         end else if (t > 1 && fl !== 8'b1000_0000) begin
            fails++;
            $display("FAIL err_idle t=%0d got %b exp %b", t, fl, 8'b1000_0000);
         end
      end
      tests++;
      if (ctrl_row !== 4'd0 || ctrl_col !== 4'd5) begin
         fails++;
         $display("FAIL err_ctrl_len got %0d/%0d exp 0/5", ctrl_row, ctrl_col);
      end
      settle(10);
   endtask

   task automatic test_wrap();
      row = 4'd2; col = 4'd1; a_addr = 12'hFF0; b_addr = 12'h000;
      req_vld = 1'b1;
      tick();
      req_vld = 1'b0;
      tests++;
      if (rd_vld !== 1'b1 || rd_addr !== 8'hFF) begin
         fails++;
         $display("FAIL wrap_t1 got vld %b addr %h exp 1 ff", rd_vld, rd_addr);
      end
      tick();
      tests++;
      if (rd_vld !== 1'b1 || rd_addr !== 8'h00) begin
         fails++;
         $display("FAIL wrap_t2 got vld %b addr %h exp 1 00", rd_vld, rd_addr);
      end
      tests++;
      if (a_alloc !== 1'b1 || alloc_data !== {16{8'hFF}}) begin
         fails++;
         $display("FAIL wrap_alloc got vld %b data %h", a_alloc, alloc_data);
      end
      settle(20);
   endtask

   task automatic test_lat3();
      logic [7:0] ef [8] = '{8'h40, 8'h40, 8'h00, 8'h20, 8'h10, 8'h0C, 8'h02, 8'h80};
      row = 4'd1; col = 4'd1; a_addr = 12'h050; b_addr = 12'h070;
      req_vld = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick();
         req_vld = 1'b0;
         tests++;
         if (fl_3 !== ef[t-1]) begin
            fails++;
            $display("FAIL lat3_flags t=%0d got %b exp %b", t, fl_3, ef[t-1]);
         end
         if (t == 4 || t == 5) begin
            tests++;
            if (alloc_addr_3 !== 8'd0 ||
                alloc_data_3 !== ((t == 4) ? {16{8'h05}} : {16{8'h07}})) begin
               fails++;
               $display("FAIL lat3_alloc t=%0d got idx %h data %h", t, alloc_addr_3, alloc_data_3);
            end
         end
      end
      settle(20);
   endtask

   task automatic test_back_to_back();
      row = 4'd1; col = 4'd1; a_addr = 12'h100; b_addr = 12'h200;
      req_vld = 1'b1;
      for (int t = 1; t <= 7; t++) begin
         tick();
         if (t == 2) begin
            row = 4'd3;
            a_addr = 12'h400;
         end
         if (t <= 5) begin
            tests++;
            if (rdy !== 1'b0) begin
               fails++;
               $display("FAIL b2b_rdy_busy t=%0d got %b exp 0", t, rdy);
            end
         end
         if (t == 3) begin
            tests++;
            if (ctrl_row !== 4'd1) begin
               fails++;
               $display("FAIL b2b_len_hold got %0d exp 1", ctrl_row);
            end
         end
         if (t == 5) begin
            tests++;
            if (done !== 1'b1) begin
               fails++;
               $display("FAIL b2b_done got %b exp 1", done);
            end
         end
         if (t == 6) begin
            tests++;
            if (rdy !== 1'b1 || rd_vld !== 1'b0) begin
               fails++;
               $display("FAIL b2b_idle got rdy %b vld %b exp 1 0", rdy, rd_vld);
            end
         end
         if (t == 7) begin
            tests++;
            if (rd_vld !== 1'b1 || rd_addr !== 8'h40 || ctrl_row !== 4'd3) begin
               fails++;
               $display("FAIL b2b_second got vld %b addr %h row %0d exp 1 40 3",
                        rd_vld, rd_addr, ctrl_row);
            end
         end
      end
      settle(30);
   endtask

   task automatic test_reset_mid();
      row = 4'd3; col = 4'd3; a_addr = 12'h000; b_addr = 12'h100;
      req_vld = 1'b1;
      for (int t = 1; t <= 4; t++) begin
         tick();
         req_vld = 1'b0;
      end
      tests++;
      if (fl !== 8'b0110_0000 || rd_addr !== 8'h10 || alloc_addr !== 8'd2) begin
         fails++;
         $display("FAIL rstmid_pre got %b addr %h idx %h exp 01100000 10 02", fl, rd_addr, alloc_addr);
      end
      rst_n = 1'b0;
      tick();
      tests++;
      if (fl !== 8'b1000_0000 || fl_3 !== 8'b1000_0000) begin
         fails++;
         $display("FAIL rstmid_flags got %b / %b exp 10000000", fl, fl_3);
      end
      tests++;
      if ({rd_addr, alloc_addr, ctrl_row, ctrl_col} !== 24'h0) begin
         fails++;
         $display("FAIL rstmid_fields got %h exp 000000", {rd_addr, alloc_addr, ctrl_row, ctrl_col});
      end
      rst_n = 1'b1;
      for (int t = 0; t < 6; t++) begin
         tick();
         tests++;
         if (fl !== 8'b1000_0000 || fl_3 !== 8'b1000_0000) begin
            fails++;
            $display("FAIL rstmid_stale t=%0d got %b / %b exp 10000000", t, fl, fl_3);
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_basic();
      test_error();
      test_wrap();
      test_lat3();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lsu_mm_seq.md
LSU_MM_SEQ -- requirements
Module: lsu_mm_seq

Interface
REQ-001 Parameter: RAM_RD_LAT, default 1, fixed RAM read latency in cycles (legal 1..4).
REQ-002 Clocking: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 lsu_mm_seq_req_vld  in  1  matmul request valid.
REQ-006 lsu_mm_seq_req_rdy  out  1  request accepted when vld&rdy.
REQ-007 lsu_mm_seq_req_row_len  in  4  A rows to fetch / buffer row_len.
REQ-008 lsu_mm_seq_req_col_len  in  4  B rows to fetch / buffer col_len.
REQ-009 lsu_mm_seq_req_a_addr  in  12  A byte address; bits [11:4] are the RAM line.
REQ-010 lsu_mm_seq_req_b_addr  in  12  B byte address; bits [11:4] are the RAM line.
REQ-011 lsu_mm_seq_ram_read_vld  out  1  RAM read strobe.
REQ-012 lsu_mm_seq_ram_read_addr  out  8  RAM line address.
REQ-013 lsu_mm_seq_ram_rdata  in  128  RAM data, valid RAM_RD_LAT cycles after strobe.
REQ-014 lsu_mm_seq_a_alloc_vld  out  1  write line into A buffer.
REQ-015 lsu_mm_seq_b_alloc_vld  out  1  write line into B buffer.
REQ-016 lsu_mm_seq_alloc_addr  out  8  buffer entry index (0-based).
REQ-017 lsu_mm_seq_alloc_data  out  128  line data to buffers.
REQ-018 lsu_mm_seq_a_ctrl_vld / lsu_mm_seq_b_ctrl_vld  out  1 each  stream enable to A/B buffers.
REQ-019 lsu_mm_seq_ctrl_row_len / lsu_mm_seq_ctrl_col_len  out  4 each  captured lengths.
REQ-020 lsu_mm_seq_done  out  1  one-cycle completion pulse.
REQ-021 lsu_mm_seq_err  out  1  qualifies done; 1 = rejected request.

Function
REQ-022 FSM states SHALL be IDLE, FETCH_A, FETCH_B, DRAIN, STREAM, DONE.
REQ-023 IDLE: req_rdy=1 only in IDLE; on handshake capture all req fields; zero length (either) -> DONE with err=1, else FETCH_A.
REQ-024 FETCH_A: one read per cycle, addr = a_addr[11:4]+cnt, cnt 0..row_len-1; after last -> FETCH_B with no bubble.
REQ-025 FETCH_B: col_len reads from b_addr[11:4]+cnt; after last -> DRAIN.
REQ-026 Address add SHALL be 8-bit modulo 256 (0xFF+1 wraps to 0x00).
REQ-027 Each read SHALL push {sel A/B, entry idx} into a RAM_RD_LAT-deep tag pipe; pipe output drives a/b_alloc_vld and alloc_addr; alloc_data = ram_rdata combinationally.
REQ-028 DRAIN SHALL last exactly RAM_RD_LAT cycles, then -> STREAM.
REQ-029 STREAM: a_ctrl_vld=b_ctrl_vld=1 for exactly row_len+col_len-1 cycles (6-bit counter), then -> DONE.
REQ-030 DONE: done=1 for one cycle, err as captured, then -> IDLE.
REQ-031 ctrl_row_len/ctrl_col_len SHALL hold captured values from acceptance until next acceptance.
REQ-032 req_vld outside IDLE SHALL be ignored; req inputs sampled only on handshake.
REQ-033 Latency (LAT=1, row=2, col=3): accept T0, reads T1-T5, DRAIN T6, STREAM T7-T10, done T11.
REQ-034 Error latency: accept T0, done+err T1, no RAM reads, no allocs.

Reset
REQ-035 rst_n low in any state SHALL force IDLE, clear tag pipe, counters, captured fields; all outputs 0 except req_rdy=1 from first cycle after reset.
REQ-036 No alloc_vld SHALL appear after reset for reads issued before reset.

Structure
REQ-037 Package lsu_mm_pkg SHALL hold state encoding, LINE_W=128, ADDR_W=8, LEN_W=4, CYC_W=6.
REQ-038 Tag pipe SHALL be sub-module lsu_mm_rd_tag_pipe (parameter RAM_RD_LAT, resettable).

Verification
REQ-039 row=2,col=3,a=0x120,b=0x300,LAT=1 -> reads 0x12,0x13,0x30,0x31,0x32 T1-T5; A alloc idx0,1 T2-T3; B idx0-2 T4-T6; ctrl_vld T7-T10; done T11, err=0.
REQ-040 row=0,col=5 -> done=1,err=1 at T1; read_vld never asserted.
REQ-041 a_addr=0xFF0,row=2 -> read addrs 0xFF then 0x00.
REQ-042 LAT=3,row=1,col=1 -> DRAIN 3 cycles; B alloc 3 cycles after its read; STREAM 1 cycle.
REQ-043 req_vld held high through busy period -> second request accepted only in IDLE after done.
REQ-044 rst_n low during FETCH_B -> next cycle IDLE, all outputs 0, rdy=1; no stale alloc_vld afterwards.
